// File: rtl/dac_tx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// dac_tx
//
// Serial DAC transmitter for the filter output path. When the sample strobe
// arrives, the signed Q p.f filter output is clamped to the representable
// +/-1.0 window, turned into a 12-bit offset-binary code and shifted out
// MSB first as a 16-bit frame {4'b0000, code} to a DAC121S101-class device.
//
// Ports:
//   sclk      in   system clock, everything moves on its rising edge
//   rst       in   synchronous active-high reset, beats a coincident start
//   start     in   one-cycle sample strobe, yk valid in the same cycle
//   yk        in   signed sample, Q p.f, Width = 1+p+f bits
//   busy      out  frame in progress (shift or done phase)
//   done      out  one-cycle pulse when the frame has been sent
//   overrun   out  one-cycle pulse when a start arrived while busy
//   sat       out  last accepted sample was clamped
//   dac_sclk  out  serial clock to the DAC, idles high
//   dac_sync  out  active-low frame select
//   dac_din   out  serial data, MSB first, sampled by the DAC on falling sclk
// ----------------------------------------------------------------------------
module dac_tx #(
  parameter int p     = 8,
  parameter int f     = 14,
  parameter int Width = 1 + p + f,
  parameter int DIV   = 2
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             start,
  input  logic [Width-1:0] yk,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             sat,
  output logic             dac_sclk,
  output logic             dac_sync,
  output logic             dac_din
);

  // Width of the phase counter that walks through one dac_sclk period.
  localparam int PhW = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
  localparam logic [PhW-1:0] HalfLast = PhW'(DIV - 1);
  localparam logic [PhW-1:0] FullLast = PhW'(2 * DIV - 1);

  // +1.0 and -1.0 expressed in the Q p.f input format.
  localparam logic signed [Width-1:0] PosLimit = Width'(2 ** f);
  localparam logic signed [Width-1:0] NegLimit = -PosLimit;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_t;

  state_t            state_q, state_d;
  logic [14:0]       shift_q, shift_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              sat_q, sat_d;
  logic              dacSclk_q, dacSclk_d;
  logic              dacSync_q, dacSync_d;
  logic              dacDin_q, dacDin_d;

  logic signed [Width-1:0] ykS;
  logic                    ykHigh;
  logic                    ykLow;
  logic [11:0]             code;
  logic [15:0]             frameNext;

  // Sample conversion. Inside the +/-1.0 window, an arithmetic shift by
  // (f-11) leaves an 11-bit-plus-sign value in [-2048, 2047]; adding 2048
  // modulo 4096 is the same as inverting its sign bit, so the code is just
  // the inverted sign bit (yk[f]) followed by yk[f-1:f-11]. Floor truncation
  // comes for free from dropping the low bits of a two's-complement number.
  always_comb begin
    ykS    = $signed(yk);
    ykHigh = (ykS >= PosLimit);
    ykLow  = (ykS < NegLimit);
    if (ykHigh) begin
      code = 12'hFFF;
    end else if (ykLow) begin
      code = 12'h000;
    end else begin
      code = {~yk[f], yk[f-1 -: 11]};
    end
    frameNext = {4'b0000, code};
  end

  // Frame sequencing. The shift register holds the bits still to be sent;
  // dac_din already carries the current bit, so the register's MSB is always
  // the next one. Every output is computed here as a next value and then
  // registered, so nothing combinational reaches the pins.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    sat_d     = sat_q;
    dacSclk_d = dacSclk_q;
    dacSync_d = dacSync_q;
    dacDin_d  = dacDin_q;

    case (state_q)
      StIdle: begin
        busy_d    = 1'b0;
        dacSync_d = 1'b1;
        dacSclk_d = 1'b1;
        dacDin_d  = 1'b0;
        if (start) begin
          state_d   = StShift;
          shift_d   = frameNext[14:0];
          sat_d     = ykHigh | ykLow;
          bitCnt_d  = 4'd15;
          phase_d   = '0;
          busy_d    = 1'b1;
          dacSync_d = 1'b0;
          dacDin_d  = frameNext[15];
        end
      end

      StShift: begin
        overrun_d = start;
        phase_d   = phase_q + PhW'(1);
        // End of the high half: drop dac_sclk so the DAC samples dac_din.
        if (phase_q == HalfLast) begin
          dacSclk_d = 1'b0;
        end
        // End of the low half: either present the next bit with a rising
        // dac_sclk, or close the frame after the last bit.
        if (phase_q == FullLast) begin
          phase_d   = '0;
          dacSclk_d = 1'b1;
          if (bitCnt_q == 4'd0) begin
            state_d   = StDone;
            dacSync_d = 1'b1;
            dacDin_d  = 1'b0;
            done_d    = 1'b1;
          end else begin
            bitCnt_d = bitCnt_q - 4'd1;
            dacDin_d = shift_q[14];
            shift_d  = {shift_q[13:0], 1'b0};
          end
        end
      end

      StDone: begin
        overrun_d = start;
        state_d   = StIdle;
        busy_d    = 1'b0;
        dacSync_d = 1'b1;
        dacSclk_d = 1'b1;
        dacDin_d  = 1'b0;
      end

      default: begin
        state_d   = StIdle;
        busy_d    = 1'b0;
        dacSync_d = 1'b1;
        dacSclk_d = 1'b1;
        dacDin_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset wins over everything, so a reset in
  // the middle of a frame raises dac_sync at once and the DAC throws away
  // the partial word; no done pulse is produced for it.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      phase_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      sat_q     <= 1'b0;
      dacSclk_q <= 1'b1;
      dacSync_q <= 1'b1;
      dacDin_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      sat_q     <= sat_d;
      dacSclk_q <= dacSclk_d;
      dacSync_q <= dacSync_d;
      dacDin_q  <= dacDin_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign sat      = sat_q;
  assign dac_sclk = dacSclk_q;
  assign dac_sync = dacSync_q;
  assign dac_din  = dacDin_q;

endmodule

// File: tb/tb_dac_tx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_dac_tx
//
// Bench for dac_tx with default parameters. A timeline model tracks where in
// a frame the block should be and derives every output from the frame timing
// formulas; a receiver captures dac_din on falling dac_sclk edges so whole
// frames can be compared with hand-computed words.
// ----------------------------------------------------------------------------
module tb_dac_tx;

  localparam int P     = 8;
  localparam int F     = 14;
  localparam int W     = 1 + P + F;
  localparam int DIV   = 2;
  localparam int Per   = 2 * DIV;
  localparam int Last  = 32 * DIV;

  logic         sclk;
  logic         rst;
  logic         start;
  logic [W-1:0] yk;
  logic         busy;
  logic         done;
  logic         overrun;
  logic         sat;
  logic         dac_sclk;
  logic         dac_sync;
  logic         dac_din;

  int nChecks;
  int nFails;
  int cycleNo;

  dac_tx #(.p(P), .f(F), .Width(W), .DIV(DIV)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .start    (start),
    .yk       (yk),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .sat      (sat),
    .dac_sclk (dac_sclk),
    .dac_sync (dac_sync),
    .dac_din  (dac_din)
  );

  // 10 ns system clock.
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Cycle index, bumped on every rising edge.
  initial cycleNo = 0;
  always @(posedge sclk) cycleNo++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycleNo, act, exp);
    end
  endtask

  // Reference conversion written straight from the arithmetic rules:
  // clamp at +/-1.0, otherwise floor(yk / 2^(F-11)) + 2048.
  function automatic logic [15:0] expectFrame(input int y);
    int scale;
    int q;
    scale = 2 ** (F - 11);
    if (y >= 2 ** F) return 16'h0FFF;
    if (y < -(2 ** F)) return 16'h0000;
    q = y / scale;
    if ((y % scale != 0) && (y < 0)) q = q - 1;
    return 16'(q + 2048);
  endfunction

  function automatic logic expectSat(input int y);
    return (y >= 2 ** F) || (y < -(2 ** F));
  endfunction

  // Timeline model. relM is the position of the current cycle inside a
  // frame: 0 when idle, 1..Last while shifting, Last+1 for the done cycle.
  int          relM;
  logic [15:0] mFrame;
  logic        mSat;
  logic        mOverrun;
  logic        modelReady;

  initial begin
    relM       = 0;
    mFrame     = '0;
    mSat       = 1'b0;
    mOverrun   = 1'b0;
    modelReady = 1'b0;
  end

  always @(posedge sclk) begin
    if (rst) begin
      relM       = 0;
      mSat       = 1'b0;
      mOverrun   = 1'b0;
      modelReady = 1'b1;
    end else begin
      mOverrun = 1'b0;
      if (relM == 0) begin
        if (start) begin
          mFrame = expectFrame(int'($signed(yk)));
          mSat   = expectSat(int'($signed(yk)));
          relM   = 1;
        end
      end else begin
        if (start) mOverrun = 1'b1;
        relM = (relM == Last + 1) ? 0 : relM + 1;
      end
    end
  end

  // Compare every output with the model on each falling system edge.
  always @(negedge sclk) begin
    if (modelReady) begin
      logic inFrame;
      logic eSclk;
      logic eDin;
      inFrame = (relM >= 1) && (relM <= Last);
      eSclk   = inFrame ? (((relM - 1) % Per) < DIV) : 1'b1;
      eDin    = inFrame ? mFrame[15 - (relM - 1) / Per] : 1'b0;
      checkOutput("mdl_busy",     32'(busy),     32'(relM != 0));
      checkOutput("mdl_done",     32'(done),     32'(relM == Last + 1));
      checkOutput("mdl_overrun",  32'(overrun),  32'(mOverrun));
      checkOutput("mdl_sat",      32'(sat),      32'(mSat));
      checkOutput("mdl_dac_sync", 32'(dac_sync), 32'(!inFrame));
      checkOutput("mdl_dac_sclk", 32'(dac_sclk), 32'(eSclk));
      checkOutput("mdl_dac_din",  32'(dac_din),  32'(eDin));
    end
  end

  // DAC-side receiver: clears on frame select, captures on falling dac_sclk.
  logic [15:0] rxShift;
  int          rxCount;
  int          doneCount;
  initial begin
    rxShift   = '0;
    rxCount   = 0;
    doneCount = 0;
  end
  always @(negedge dac_sync) begin
    rxShift = '0;
    rxCount = 0;
  end
  always @(negedge dac_sclk) begin
    if (dac_sync === 1'b0) begin
      rxShift = {rxShift[14:0], dac_din};
      rxCount++;
    end
  end
  always @(posedge sclk) if (done === 1'b1) doneCount++;

  // Advance to cycle n of a frame whose cycle 0 was c0 (just past the edge).
  task automatic gotoCycle(input int c0, input int n);
    while (cycleNo - c0 < n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  // Issue one start strobe with sample y; returns the cycle-0 index.
  task automatic applyStimulus(input int y, output int c0);
    @(posedge sclk);
    #1;
    start = 1'b1;
    yk    = W'(y);
    c0    = cycleNo;
    @(posedge sclk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done with a bounded budget and check cycle, frame and sat.
  task automatic waitFrame(input int c0, input logic [15:0] expF, input logic expS);
    int dc;
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sclk);
      if (done === 1'b1) begin
        dc = cycleNo - c0;
        break;
      end
    end
    checkOutput("done_cycle", 32'(dc), 32'd65);
    checkOutput("rx_frame",   32'(rxShift), 32'(expF));
    checkOutput("rx_bits",    32'(rxCount), 32'd16);
    checkOutput("sat",        32'(sat), 32'(expS));
    @(negedge sclk);
    checkOutput("busy_end",   32'(busy), 32'd0);
  endtask

  task automatic runFrame(input int y, input logic [15:0] expF, input logic expS);
    int c0;
    applyStimulus(y, c0);
    waitFrame(c0, expF, expS);
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int d0;
    nChecks = 0;
    nFails  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    yk      = '0;

    $display("[TB] reset");
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_done",     32'(done),     32'd0);
    checkOutput("rst_overrun",  32'(overrun),  32'd0);
    checkOutput("rst_sat",      32'(sat),      32'd0);
    checkOutput("rst_dac_sclk", 32'(dac_sclk), 32'd1);
    checkOutput("rst_dac_sync", 32'(dac_sync), 32'd1);
    checkOutput("rst_dac_din",  32'(dac_din),  32'd0);
    @(posedge sclk);
    #1;
    rst = 1'b0;

    $display("[TB] single frames");
    runFrame(0,       16'h0800, 1'b0);
    runFrame(40960,   16'h0FFF, 1'b1);
    runFrame(-49152,  16'h0000, 1'b1);
    runFrame(-8192,   16'h0400, 1'b0);
    runFrame(16383,   16'h0FFF, 1'b0);
    runFrame(16384,   16'h0FFF, 1'b1);
    runFrame(-16384,  16'h0000, 1'b0);
    runFrame(-16385,  16'h0000, 1'b1);
    runFrame(-1,      16'h07FF, 1'b0);
    runFrame(12345,   16'h0E07, 1'b0);

    $display("[TB] overrun");
    applyStimulus(0, c0);
    gotoCycle(c0, 10);
    start = 1'b1;
    yk    = W'(8192);
    gotoCycle(c0, 11);
    start = 1'b0;
    @(negedge sclk);
    checkOutput("overrun_c11", 32'(overrun), 32'd1);
    gotoCycle(c0, 12);
    @(negedge sclk);
    checkOutput("overrun_c12", 32'(overrun), 32'd0);
    gotoCycle(c0, 65);
    start = 1'b1;
    yk    = W'(8192);
    @(negedge sclk);
    checkOutput("done_c65",    32'(done),    32'd1);
    checkOutput("rx_ovr_frame", 32'(rxShift), 32'h0800);
    checkOutput("sat_ovr",     32'(sat),     32'd0);
    gotoCycle(c0, 66);
    start = 1'b0;
    @(negedge sclk);
    checkOutput("overrun_c66", 32'(overrun), 32'd1);
    checkOutput("busy_c66",    32'(busy),    32'd0);
    gotoCycle(c0, 67);
    @(negedge sclk);
    checkOutput("idle_c67",    32'(busy),    32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(40960, c0);
    d0 = doneCount;
    gotoCycle(c0, 20);
    rst = 1'b1;
    gotoCycle(c0, 21);
    rst = 1'b0;
    @(negedge sclk);
    checkOutput("abort_dac_sync", 32'(dac_sync), 32'd1);
    checkOutput("abort_dac_sclk", 32'(dac_sclk), 32'd1);
    checkOutput("abort_dac_din",  32'(dac_din),  32'd0);
    checkOutput("abort_busy",     32'(busy),     32'd0);
    checkOutput("abort_sat",      32'(sat),      32'd0);
    gotoCycle(c0, 80);
    checkOutput("abort_no_done",  32'(doneCount - d0), 32'd0);
    runFrame(-8192, 16'h0400, 1'b0);

    $display("[TB] back-to-back");
    applyStimulus(8192, c0);
    gotoCycle(c0, 64);
    @(negedge sclk);
    checkOutput("b2b_sync_c64", 32'(dac_sync), 32'd0);
    gotoCycle(c0, 65);
    @(negedge sclk);
    checkOutput("b2b_sync_c65", 32'(dac_sync), 32'd1);
    checkOutput("b2b_frame1",   32'(rxShift),  32'h0C00);
    gotoCycle(c0, 66);
    start = 1'b1;
    yk    = W'(-40960);
    @(negedge sclk);
    checkOutput("b2b_sync_c66", 32'(dac_sync), 32'd1);
    gotoCycle(c0, 67);
    start = 1'b0;
    @(negedge sclk);
    checkOutput("b2b_sync_c67", 32'(dac_sync), 32'd0);
    checkOutput("b2b_busy_c67", 32'(busy),     32'd1);
    waitFrame(c0 + 66, 16'h0000, 1'b1);

    repeat (3) @(posedge sclk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dac_tx.md
# dac_tx

Serial DAC transmitter for the filter output path. On a sample strobe it captures the signed fixed-point filter output `yk` (Q p.f), saturates it and converts it to a 12-bit offset-binary code. It then shifts a 16-bit frame, MSB first, to an external SPI-style DAC (DAC121S101-class: 4 zero control bits followed by 12 data bits). It shares the sample strobe with the filter's `enable`, so one DAC frame is sent per filter update.

## Interface

Parameters:
- `p`, 8, integer bits of the sample format
- `f`, 14, fraction bits of the sample format; must be ≥ 11
- `Width`, 1+p+f, sample width (sign + p + f)
- `DIV`, 2, `sclk` cycles per half-period of `dac_sclk`; must be ≥ 1

Ports:
- `sclk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle sample strobe; `yk` is valid in the same cycle
- `yk`  in  Width  signed sample to transmit, Q p.f
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at end of frame
- `overrun`  out  1  one-cycle pulse: a `start` was rejected
- `sat`  out  1  the last accepted sample was clamped
- `dac_sclk`  out  1  serial clock to the DAC; idles high
- `dac_sync`  out  1  active-low frame select
- `dac_din`  out  1  serial data, MSB first

## Operation

- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `overrun`=0, `sat`=0, `dac_sclk`=1, `dac_sync`=1, `dac_din`=0. The state machine returns to IDLE and the counters clear.
- Conversion, evaluated on the accepted `start`:
  - if `yk` ≥ 2^f, code=4095 and `sat`=1
  - else if `yk` < −2^f, code=0 and `sat`=1
  - else code=(`yk` >>> (f−11)) + 2048, floor truncation, and `sat`=0
- Frame = {4'b0000, code[11:0]}.
- `sat` holds its value until the next accepted `start`.
- States:
  - IDLE: `start`=1 → latch frame and `sat`, load bit counter=15 and phase counter=0, go to SHIFT.
  - SHIFT: `dac_sync`=0, `busy`=1.
    - `dac_sclk` is high for DIV cycles, then low for DIV cycles.
    - The DAC samples `dac_din` on each falling edge of `dac_sclk`.
    - `dac_din` updates when `dac_sclk` returns high, i.e. the next bit is presented.
    - After the low half of the 16th bit, go to DONE.
  - DONE: one cycle; `dac_sync`=1, `dac_sclk`=1, `dac_din`=0, `done`=1, `busy`=1. Then go to IDLE.
- A `start` in SHIFT or DONE is ignored: the frame in flight is unchanged and `overrun` pulses for 1 cycle.
- `rst` overrides everything, including a coincident `start`.
- Reset mid-frame aborts the frame: no `done`, and the DAC sees `dac_sync` rise, which discards the partial frame.

## Timing

- Let cycle 0 be the cycle in which `start` is sampled high in IDLE.
- Cycle 1: `dac_sync`=0, `busy`=1, `dac_sclk`=1, `dac_din`=frame[15].
- Bit k (k=15..0) is driven from cycle 1+(15−k)·2·DIV.
- Falling edge of bit k at cycle 1+(15−k)·2·DIV+DIV.
- DONE at cycle 32·DIV+1: `dac_sync`=1, `done`=1.
- Cycle 32·DIV+2: `busy`=0 and the block is in IDLE; a new `start` is accepted from this cycle.
- Minimum sample period: 32·DIV+2 cycles. `overrun` is asserted in the cycle after the rejected `start`.
- With DIV=2: `dac_sync` is low for 64 cycles and the `dac_sclk` period is 4 `sclk` cycles.

## Test plan

All scenarios use defaults p=8, f=14, DIV=2; the bench samples `dac_din` on `dac_sclk` falling edges.

- `yk`=0 → frame 0x0800; `done` at cycle 65; `busy` low at cycle 66; `sat`=0.
- `yk`=+2.5 (0x00A000) → frame 0x0FFF, `sat`=1; `yk`=−3.0 → frame 0x0000, `sat`=1.
- `yk`=−0.5 (−8192) → code 1024, frame 0x0400, `sat`=0; `yk`=2^14−1 → frame 0x0FFF, `sat`=0.
- `start` at cycle 0 with `yk`=0; second `start` at cycle 10 with `yk`=+0.5 → `overrun`=1 at cycle 11 only; transmitted frame stays 0x0800; a `start` at cycle 65 (DONE) also raises `overrun`.
- `rst` at cycle 20 mid-frame → cycle 21: `dac_sync`=1, `dac_sclk`=1, `dac_din`=0, `busy`=0, no `done`. A following `start` with `yk`=−0.5 transmits 0x0400 correctly.
- Back-to-back: `start` at cycles 0 and 66 → two complete frames; `dac_sync` is high for exactly 2 cycles between them (cycles 65–66).
